// File: rtl/ip_header_parser.sv
// Front-end parser: picks untagged IPv4 (IHL 5) frames out of the Ethernet byte stream and issues
// an insert (source IP) then a look-up (destination IP) request. Optional header checksum: IPV4_CSUM_CHECK_EN.
module ip_header_parser #(
  parameter int          IP_ADDR_W      = 32,
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
  parameter int          HDR_LAST_IDX   = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic                 eof_i,
  output logic                 insert_val_o,
  output logic                 look_up_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o,
  output logic                 frame_drop_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_EMIT_INS = 3'd2,
    S_EMIT_LKP = 3'd3,
    S_SKIP     = 3'd4
  } state_t;

  localparam logic [5:0] LP_LAST = 6'(HDR_LAST_IDX);

  state_t               r_state, w_state_nxt;
  state_t               r_ret, w_ret_nxt;
  logic [5:0]           r_cnt, w_cnt_nxt;
  logic [7:0]           r_et_hi;
  logic [IP_ADDR_W-1:0] r_src, r_dst;
  logic                 w_fail, w_drop, w_sof, w_hdr_byte;

  assign w_sof      = valid_i & sof_i;
  assign w_hdr_byte = valid_i & ~sof_i & (r_state == S_HDR);

`ifdef IPV4_CSUM_CHECK_EN
  logic [7:0]  r_csum_hi;
  logic [15:0] r_csum;
  logic [15:0] w_csum_nxt;

  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    logic [16:0] sum;
    sum = {1'b0, acc} + {1'b0, word};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  assign w_csum_nxt = csum_add(r_csum, {r_csum_hi, data_i});

  // Header checksum: even bytes are held as the high half, odd bytes close the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum_hi <= 8'd0;
      r_csum    <= 16'd0;
    end else if (w_sof) begin
      r_csum_hi <= 8'd0;
      r_csum    <= 16'd0;
    end else if (w_hdr_byte && (r_cnt >= 6'd14) && (r_cnt <= LP_LAST)) begin
      if (r_cnt[0]) r_csum <= w_csum_nxt;
      else          r_csum_hi <= data_i;
    end
  end
`endif

  // Field check on the header byte currently presented.
  always_comb begin
    w_fail = 1'b0;
    if (r_cnt == 6'd13) begin
      w_fail = ({r_et_hi, data_i} != ETHERTYPE_IPV4);
    end else if (r_cnt == 6'd14) begin
      w_fail = (data_i != 8'h45);
`ifdef IPV4_CSUM_CHECK_EN
    end else if (r_cnt == LP_LAST) begin
      w_fail = (w_csum_nxt != 16'hFFFF);
`endif
    end else begin
      w_fail = 1'b0;
    end
  end

  // Next-state logic; r_ret remembers where to go once both requests have been issued.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE, S_SKIP: begin
        if (w_sof) begin
          w_cnt_nxt   = 6'd1;
          w_drop      = eof_i;
          w_state_nxt = eof_i ? S_IDLE : S_HDR;
        end else if (valid_i && eof_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_HDR: begin
        if (w_sof) begin
          w_drop      = 1'b1;
          w_cnt_nxt   = 6'd1;
          w_state_nxt = eof_i ? S_IDLE : S_HDR;
        end else if (valid_i) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (w_fail) begin
            w_drop      = 1'b1;
            w_state_nxt = eof_i ? S_IDLE : S_SKIP;
          end else if (r_cnt == LP_LAST) begin
            w_state_nxt = S_EMIT_INS;
            w_ret_nxt   = eof_i ? S_IDLE : S_SKIP;
          end else if (eof_i) begin
            w_drop      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HDR;
          end
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_EMIT_INS, S_EMIT_LKP: begin
        // A following frame may already be starting; count its bytes while emitting.
        if (w_sof) begin
          w_cnt_nxt = 6'd1;
          w_drop    = eof_i;
          w_ret_nxt = eof_i ? S_IDLE : S_HDR;
        end else if (valid_i && (r_ret == S_HDR)) begin
          w_cnt_nxt = r_cnt + 6'd1;
          w_drop    = eof_i;
          w_ret_nxt = eof_i ? S_IDLE : S_HDR;
        end else if (valid_i && eof_i) begin
          w_ret_nxt = S_IDLE;
        end else begin
          w_ret_nxt = r_ret;
        end
        w_state_nxt = (r_state == S_EMIT_INS) ? S_EMIT_LKP : w_ret_nxt;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ret_nxt   = S_SKIP;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  // State, counter and address capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ret   <= S_SKIP;
      r_cnt   <= 6'd0;
      r_et_hi <= 8'd0;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hdr_byte && (r_cnt == 6'd12)) r_et_hi <= data_i;
      if (w_hdr_byte && (r_cnt >= 6'd26) && (r_cnt <= 6'd29)) r_src <= {r_src[IP_ADDR_W-9:0], data_i};
      if (w_hdr_byte && (r_cnt >= 6'd30) && (r_cnt <= LP_LAST)) r_dst <= {r_dst[IP_ADDR_W-9:0], data_i};
    end
  end

  // Registered request bus: pulses line up with the EMIT states, address holds between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insert_val_o  <= 1'b0;
      look_up_val_o <= 1'b0;
      frame_drop_o  <= 1'b0;
      ip_addr_o     <= '0;
    end else begin
      insert_val_o  <= (w_state_nxt == S_EMIT_INS);
      look_up_val_o <= (w_state_nxt == S_EMIT_LKP);
      frame_drop_o  <= w_drop;
      if (w_state_nxt == S_EMIT_INS)      ip_addr_o <= r_src;
      else if (w_state_nxt == S_EMIT_LKP) ip_addr_o <= r_dst;
      else                                ip_addr_o <= ip_addr_o;
    end
  end

endmodule

// File: tb/tb_ip_header_parser.sv
// Bench for ip_header_parser: builds Ethernet/IPv4 frames, predicts requests and drops from the
// frame contents, and compares against the observed event stream.
module tb_ip_header_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic        valid_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
  logic        insert_val_o, look_up_val_o, frame_drop_o;
  logic [31:0] ip_addr_o;

  ip_header_parser dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i), .eof_i(eof_i),
    .insert_val_o(insert_val_o), .look_up_val_o(look_up_val_o),
    .ip_addr_o(ip_addr_o), .frame_drop_o(frame_drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [7:0] bq_t[$];

  int errors = 0, checks = 0, overlap = 0;
  logic [31:0] exp_ins_a[$], got_ins_a[$], exp_lkp_a[$], got_lkp_a[$];
  int exp_ins_c[$], got_ins_c[$], exp_lkp_c[$], got_lkp_c[$], exp_drop_c[$], got_drop_c[$];
  bit pend = 1'b0;
  bit have_lkp = 1'b0;
  logic [31:0] last_lkp = 32'd0;

  always @(negedge clk) begin
    if (insert_val_o) begin got_ins_a.push_back(ip_addr_o); got_ins_c.push_back(cyc); end
    if (look_up_val_o) begin got_lkp_a.push_back(ip_addr_o); got_lkp_c.push_back(cyc); end
    if (frame_drop_o) got_drop_c.push_back(cyc);
    if (insert_val_o && look_up_val_o) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    while (r > 32'hFFFF) r = (r & 32'hFFFF) + (r >> 16);
    return r;
  endfunction

  function automatic bq_t build(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] et,
                                input logic [7:0] vihl, input bit bad_csum, input int len);
    bq_t q;
    logic [7:0] h [0:19];
    logic [31:0] s;
    logic [15:0] cs;
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    q.push_back(et[15:8]);
    q.push_back(et[7:0]);
    h[0] = vihl; h[1] = 8'd0; h[2] = 8'd0; h[3] = 8'd20;
    h[4] = 8'($urandom); h[5] = 8'($urandom); h[6] = 8'h40; h[7] = 8'd0;
    h[8] = 8'd64; h[9] = 8'd17; h[10] = 8'd0; h[11] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      h[12+i] = src[31-8*i -: 8];
      h[16+i] = dst[31-8*i -: 8];
    end
    s = 32'd0;
    for (int i = 0; i < 10; i++) s = s + {16'd0, h[2*i], h[2*i+1]};
    s  = fold(s);
    cs = ~s[15:0];
    if (bad_csum) cs = cs + 16'd1;
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    for (int i = 0; i < 20; i++) q.push_back(h[i]);
    while (q.size() < len) q.push_back(8'($urandom));
    while (q.size() > len) void'(q.pop_back());
    return q;
  endfunction

  // Byte index at which the frame must be rejected; -1 = accepted, -2 = unterminated and undecided.
  function automatic int model_drop(input bq_t q, input bit eof);
    int n;
    logic [31:0] s;
    n = q.size();
    if (n >= 14 && {q[12], q[13]} != 16'h0800) return 13;
    if (n >= 15 && q[14] != 8'h45) return 14;
    if (n < 34) return eof ? n - 1 : -2;
`ifdef IPV4_CSUM_CHECK_EN
    s = 32'd0;
    for (int i = 14; i < 34; i += 2) s = s + {16'd0, q[i], q[i+1]};
    if (fold(s) != 32'hFFFF) return 33;
`endif
    return -1;
  endfunction

  task automatic send(input bq_t q, input int gap_pct, input bit eof);
    int c[$];
    int d;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(99) >= gap_pct) break;
          @(posedge clk); #1;
        end
      end
      data_i = q[i]; valid_i = 1'b1; sof_i = (i == 0); eof_i = eof && (i == q.size() - 1);
      c.push_back(cyc);
      @(posedge clk); #1;
      valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    end
    if (pend) begin exp_drop_c.push_back(c[0] + 1); pend = 1'b0; end
    d = model_drop(q, eof);
    if (d == -1) begin
      exp_ins_a.push_back({q[26], q[27], q[28], q[29]}); exp_ins_c.push_back(c[33] + 1);
      exp_lkp_a.push_back({q[30], q[31], q[32], q[33]}); exp_lkp_c.push_back(c[33] + 2);
      last_lkp = {q[30], q[31], q[32], q[33]}; have_lkp = 1'b1;
    end else if (d == -2) begin
      pend = 1'b1;
    end else begin
      exp_drop_c.push_back(c[d] + 1);
    end
  endtask

  task automatic settle(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " ins_count"}, 32'(got_ins_a.size()), 32'(exp_ins_a.size()));
    chk({tag, " lkp_count"}, 32'(got_lkp_a.size()), 32'(exp_lkp_a.size()));
    chk({tag, " drop_count"}, 32'(got_drop_c.size()), 32'(exp_drop_c.size()));
    for (int i = 0; i < exp_ins_a.size() && i < got_ins_a.size(); i++) begin
      chk({tag, " ins_addr"}, got_ins_a[i], exp_ins_a[i]);
      chk({tag, " ins_cycle"}, 32'(got_ins_c[i]), 32'(exp_ins_c[i]));
    end
    for (int i = 0; i < exp_lkp_a.size() && i < got_lkp_a.size(); i++) begin
      chk({tag, " lkp_addr"}, got_lkp_a[i], exp_lkp_a[i]);
      chk({tag, " lkp_cycle"}, 32'(got_lkp_c[i]), 32'(exp_lkp_c[i]));
    end
    for (int i = 0; i < exp_drop_c.size() && i < got_drop_c.size(); i++)
      chk({tag, " drop_cycle"}, 32'(got_drop_c[i]), 32'(exp_drop_c[i]));
    if (have_lkp) chk({tag, " addr_hold"}, ip_addr_o, last_lkp);
    exp_ins_a.delete(); got_ins_a.delete(); exp_ins_c.delete(); got_ins_c.delete();
    exp_lkp_a.delete(); got_lkp_a.delete(); exp_lkp_c.delete(); got_lkp_c.delete();
    exp_drop_c.delete(); got_drop_c.delete();
  endtask

  initial begin
    bq_t f;
    int kind, len;
    logic [15:0] et;

    repeat (3) @(posedge clk);
    #1;
    chk("reset insert", {31'd0, insert_val_o}, 32'd0);
    chk("reset lookup", {31'd0, look_up_val_o}, 32'd0);
    chk("reset drop", {31'd0, frame_drop_o}, 32'd0);
    chk("reset addr", ip_addr_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    send(build(32'h0A000001, 32'hC0A80107, 16'h0800, 8'h45, 1'b0, 60), 0, 1'b1);
    settle("basic");

    send(build($urandom, $urandom, 16'h86DD, 8'h45, 1'b0, 60), 0, 1'b1);
    send(build(32'h0A000001, 32'hC0A80107, 16'h0800, 8'h45, 1'b0, 50), 0, 1'b1);
    settle("ipv6_then_ok");

    send(build($urandom, $urandom, 16'h0800, 8'h46, 1'b0, 60), 0, 1'b1);
    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 20), 0, 1'b1);
    settle("ihl_and_trunc");

    send(build(32'h0A000001, 32'hC0A80107, 16'h0800, 8'h45, 1'b0, 40), 50, 1'b1);
    settle("gappy");

    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 20), 0, 1'b0);
    send(build(32'h01020304, 32'h05060708, 16'h0800, 8'h45, 1'b0, 46), 0, 1'b1);
    settle("restart");

    send(build(32'h0A000001, 32'hC0A80107, 16'h0800, 8'h45, 1'b1, 60), 0, 1'b1);
    settle("bad_csum");

    for (int i = 0; i < 4; i++) send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 34), 0, 1'b1);
    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 35), 0, 1'b1);
    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 2), 0, 1'b1);
    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 36), 0, 1'b1);
    settle("back_to_back");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(5);
      len  = ($urandom_range(3) == 0) ? $urandom_range(1, 33) : $urandom_range(34, 64);
      et   = (kind == 3) ? (16'($urandom) | 16'h1000) : 16'h0800;
      f    = build($urandom, $urandom, et, (kind == 4) ? 8'h46 : 8'h45, kind == 5, len);
      send(f, $urandom_range(50), 1'b1);
    end
    settle("random");

    send(build($urandom, $urandom, 16'h0800, 8'h45, 1'b0, 30), 0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midreset insert", {31'd0, insert_val_o}, 32'd0);
    chk("midreset addr", ip_addr_o, 32'd0);
    pend = 1'b0; have_lkp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    settle("midreset_quiet");
    send(build(32'hDEADBEEF, 32'h0BADF00D, 16'h0800, 8'h45, 1'b0, 48), 20, 1'b1);
    settle("after_reset");

    chk("never_both_high", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
